// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the core
// holds req_* stable until then. rsp_valid is a one-cycle pulse with no backpressure.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Slow unified memory: one request at a time, LATENCY wait states, one response pulse.
// Optional MEM_RESPONDER_FAULT_CHECK_EN flags misaligned/out-of-range requests via rsp_err.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_responder_if.slave    bus,
    output logic [1:0]        o_dbg_state
);
    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               r_we;
    logic               r_fault;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_commit;
    logic               w_in_fault;
    logic [IDX_W-1:0]   w_in_idx;
    logic               w_cm_we;
    logic               w_cm_fault;
    logic [IDX_W-1:0]   w_cm_idx;
    logic [31:0]        w_cm_wdata;

    assign w_in_idx = bus.req_addr[2 +: IDX_W];

`ifdef MEM_RESPONDER_FAULT_CHECK_EN
    assign w_in_fault = (bus.req_addr[1:0] != 2'b00) ||
                        (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    logic w_unused;
    assign w_in_fault = 1'b0;
    assign w_unused   = ^{bus.req_addr[1:0], bus.req_addr[31:2+IDX_W]};
`endif

    assign bus.req_ready = (r_state == IDLE) && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign o_dbg_state   = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = LAT;
                    w_state_nxt = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // With zero latency the commit edge is the acceptance edge, so take the live request.
    assign w_commit   = (w_state_nxt == RESP) && (r_state != RESP);
    assign w_cm_we    = (r_state == IDLE) ? bus.req_we    : r_we;
    assign w_cm_fault = (r_state == IDLE) ? w_in_fault    : r_fault;
    assign w_cm_idx   = (r_state == IDLE) ? w_in_idx      : r_idx;
    assign w_cm_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_fault <= w_in_fault;
                r_idx   <= w_in_idx;
                r_wdata <= bus.req_wdata;
            end
            if (w_commit) begin
                if (w_cm_fault) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end else begin
                    r_err <= 1'b0;
                    if (!w_cm_we) begin
                        r_rdata <= r_mem[w_cm_idx];
                    end
                end
            end
        end
    end

    // Storage is not reset; a reset on the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_cm_we && !w_cm_fault) begin
            r_mem[w_cm_idx] <= w_cm_wdata;
        end
    end
endmodule
